// File: rtl/tmds_decoder.sv
// TMDS channel decoder: finds the 10-bit word boundary in a deserialized
// stream by hunting for runs of control tokens, then decodes each aligned
// word into video data, control data and the video data enable.
module tmds_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int LOCK_TIMEOUT  = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw_word,
  input  logic       resync,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int WIN_W = $clog2(SEARCH_WINDOW + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       offset_q, offset_d, offset_inc;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [TO_W-1:0]  to_q, to_d;

  logic [9:0]  prev_q, prev_d;
  logic [18:0] cat;
  logic [9:0]  win_cand [10];
  logic [9:0]  w;
  logic        w_ctrl;
  logic [1:0]  w_tok;

  logic [9:0]  w1_q, w1_d;
  logic        ctrl1_q, ctrl1_d;
  logic [1:0]  tok1_q, tok1_d;

  logic [7:0]  d1;
  logic [7:0]  dec;

  logic [7:0]  vd_q, vd_d;
  logic [1:0]  cd_q, cd_d;
  logic        vde_q, vde_d;

  // The top bit of the newest word can never fall inside a 10-bit window
  // (largest offset is 9), so the concatenation stops at bit 18.
  assign cat = {raw_word[8:0], prev_q};

  genvar gi;
  for (gi = 0; gi < 10; gi++) begin : g_win
    assign win_cand[gi] = cat[gi +: 10];
  end

  // Select the aligned word and classify it as a control token or data.
  always_comb begin
    w = win_cand[0];
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) w = win_cand[i];
    end
    w_ctrl = 1'b1;
    w_tok  = 2'b00;
    case (w)
      10'h354: w_tok = 2'b00;
      10'h0AB: w_tok = 2'b01;
      10'h154: w_tok = 2'b10;
      10'h2AB: w_tok = 2'b11;
      default: w_ctrl = 1'b0;
    endcase
    prev_d  = raw_word;
    w1_d    = w;
    ctrl1_d = w_ctrl;
    tok1_d  = w_tok;
  end

  // Undo the optional inversion, then the XOR/XNOR chain of the encoder.
  assign d1     = w1_q[9] ? ~w1_q[7:0] : w1_q[7:0];
  assign dec[0] = d1[0];
  for (gi = 1; gi < 8; gi++) begin : g_dec
    assign dec[gi] = d1[gi] ^ d1[gi-1] ^ ~w1_q[8];
  end

  assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  // Alignment FSM: hunt for a token run per offset, then watch for loss.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    win_d    = win_q;
    to_d     = to_q;
    if (resync) begin
      state_d  = ST_SEARCH;
      offset_d = 4'd0;
      run_d    = '0;
      win_d    = '0;
      to_d     = '0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (w_ctrl && run_q == RUN_LAST) begin
            // Final token of the run: lock immediately, even on the last
            // cycle of the window.
            state_d = ST_LOCKED;
            run_d   = '0;
            win_d   = '0;
            to_d    = '0;
          end else if (win_q == WIN_LAST) begin
            offset_d = offset_inc;
            run_d    = '0;
            win_d    = '0;
          end else begin
            run_d = w_ctrl ? run_q + RUN_W'(1) : '0;
            win_d = win_q + WIN_W'(1);
          end
        end
        default: begin
          if (w_ctrl) begin
            to_d = '0;
          end else if (to_q == TO_LAST) begin
            state_d  = ST_SEARCH;
            offset_d = offset_inc;
            run_d    = '0;
            win_d    = '0;
            to_d     = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      endcase
    end
  end

  // Output stage, gated by the lock state that becomes visible at the
  // same edge so vde/vd are never nonzero while locked reads 0.
  always_comb begin
    vd_d  = 8'h00;
    cd_d  = cd_q;
    vde_d = 1'b0;
    if (state_d != ST_LOCKED) begin
      cd_d = 2'b00;
    end else if (ctrl1_q) begin
      cd_d = tok1_q;
    end else begin
      vde_d = 1'b1;
      vd_d  = dec;
    end
  end

  // All state, pipeline and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_SEARCH;
      offset_q <= 4'd0;
      run_q    <= '0;
      win_q    <= '0;
      to_q     <= '0;
      prev_q   <= 10'd0;
      w1_q     <= 10'd0;
      ctrl1_q  <= 1'b0;
      tok1_q   <= 2'b00;
      vd_q     <= 8'h00;
      cd_q     <= 2'b00;
      vde_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      win_q    <= win_d;
      to_q     <= to_d;
      prev_q   <= prev_d;
      w1_q     <= w1_d;
      ctrl1_q  <= ctrl1_d;
      tok1_q   <= tok1_d;
      vd_q     <= vd_d;
      cd_q     <= cd_d;
      vde_q    <= vde_d;
    end
  end

  assign vd     = vd_q;
  assign cd     = cd_q;
  assign vde    = vde_q;
  assign locked = (state_q == ST_LOCKED);
  assign offset = offset_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the per-channel TMDS encoder in the DVI transmit path. One instance per TMDS channel.
- Takes 10-bit raw words from an upstream 10:1 deserializer running in the pixel clock domain. Word boundary is unknown.
- Finds the word boundary by searching for control-token runs during blanking.
- Decodes each aligned word into video data (VD), control data (CD) and the video data enable (VDE).

Parameters:
- CTRL_RUN, 8: consecutive control tokens required at the current offset to declare lock.
- SEARCH_WINDOW, 4096: cycles spent at one offset before advancing. Must exceed one full line.
- LOCK_TIMEOUT, 8192: cycles in LOCKED with no control token before lock is dropped.

Ports:
- clk, input, 1: pixel clock. The only clock.
- rst_n, input, 1: synchronous, active-low reset.
- raw_word, input, 10: deserialized bits. Bit 0 is the earliest received serial bit. One word per clk.
- resync, input, 1: single-cycle pulse; forces re-search starting at offset 0.
- vd, output, 8: decoded video data.
- cd, output, 2: control data {C1,C0}; on blue = {vsync,hsync}.
- vde, output, 1: 1 when vd is valid, 0 during control periods.
- locked, output, 1: word alignment achieved.
- offset, output, 4: current bit-slip offset, 0..9.

Behaviour:
- Reset (rst_n=0 at a clk edge): vd=0, cd=0, vde=0, locked=0, offset=0, state=SEARCH, prev word=0, all counters=0. Applies identically mid-operation.
- Alignment window:
  - prev = raw_word registered each cycle. cat = {raw_word, prev} (20 bits).
  - Aligned word w = cat[offset+9 : offset]. Offset 0 selects prev unchanged.
- Control tokens (w in hex → cd):
  - 0x354 → 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
  - Anything else is a data word.
- Data decode:
  - d = w[9] ? ~w[7:0] : w[7:0]
  - vd[0] = d[0]
  - For i=1..7: vd[i] = d[i] ^ d[i-1] ^ ~w[8]. That is, XOR when w[8]=1 and XNOR when w[8]=0.
- Pipeline:
  - Stage 1 registers w and its is_ctrl flag.
  - Stage 2 registers vd/cd/vde.
  - Latency is 2 clk from the edge that samples the raw_word completing the window.
- FSM SEARCH:
  - run_cnt counts consecutive control tokens. Reset to 0 on a data word.
  - win_cnt counts cycles at the current offset.
  - run_cnt reaching CTRL_RUN → LOCKED (locked=1 next edge); offset is held.
  - Else win_cnt reaching SEARCH_WINDOW-1 → offset advances (9 wraps to 0), and run_cnt and win_cnt clear.
  - Lock and advance in the same cycle: lock wins.
- FSM LOCKED:
  - to_cnt clears on every control token and increments on every data word.
  - to_cnt reaching LOCK_TIMEOUT-1 → SEARCH, locked=0, offset+1 (wrap), counters cleared.
- resync=1 in any state → SEARCH, offset=0, counters cleared, locked=0 next edge. resync has priority over the lock and timeout transitions.
- Outputs when locked=0: vde=0 and vd=0; cd holds 0.
- Outputs when locked=1:
  - Control token: vde=0, vd=0, cd = token value.
  - Data word: vde=1, vd = decoded value, cd holds its last value.
- During SEARCH, offset changes take effect on the window in the cycle after the change. The first word after an offset change still enters the run count.
- Counter widths: $clog2 of the respective parameter+1. No overflow; all counters saturate or clear before wrapping.

Test Plan:
- Aligned stream: offset 0, 20 cycles of 0x354, then data 0x100, 0x200, then 0x0AB → locked=1 after 8 tokens; vd=0x00 then 0xFF with vde=1; then vde=0, cd=01. Latency 2 clk verified.
- Misaligned stream: serial stream delayed by 3 bits, 128 blanking tokens per 2048-cycle line, SEARCH_WINDOW=4096 → offset steps 0,1,2,3 and locks with offset=3. Decoded vd matches the encoder reference model.
- hsync/vsync: cycle all four tokens with 16-cycle runs → cd follows 00,01,10,11. cd holds 11 across a following data burst.
- Lock loss: LOCK_TIMEOUT=64, stream of only 0x100 for 64 cycles → locked drops, offset increments by 1, vde=0.
- resync while locked at offset 5 → next edge offset=0, locked=0. Correct stream then relocks.
- rst_n=0 for one edge mid-video → all outputs 0 at that edge. Block re-locks from offset 0 afterwards.
